// File: rtl/turn_timer_ctrl.sv
// Two-player turn timer: per-turn countdown with prescaler, pause, move handoff
// and a one-cycle timeout pulse when a turn runs out.
module turn_timer_ctrl #(
  parameter int N    = 4,
  parameter int LOAD = 15,
  parameter int DIV  = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         move,
  output logic [N-1:0] countdownOut,
  output logic         player,
  output logic         timeout,
  output logic         running,
  output logic [1:0]   state
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [N-1:0]  LOAD_V = N'(LOAD);
  localparam logic [PW-1:0] PMAX   = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSE  = 2'b10,
    EXPIRE = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic          player_q, player_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_s;

  assign tick_s = (presc_q == PMAX);

  // State register; reset discards any session in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= LOAD_V;
      player_q <= 1'b0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      player_q <= player_d;
      presc_q  <= presc_d;
    end
  end

  // Next-state logic; RUN priority is stop > zero count > move > pause > tick.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    player_d = player_q;
    presc_d  = presc_q;
    case (state_q)
      IDLE: begin
        cnt_d    = LOAD_V;
        player_d = 1'b0;
        presc_d  = '0;
        if (start && !stop) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_d  = IDLE;
          cnt_d    = LOAD_V;
          player_d = 1'b0;
          presc_d  = '0;
        end else if (cnt_q == '0) begin
          state_d = EXPIRE;
        end else if (move) begin
          cnt_d    = LOAD_V;
          player_d = ~player_q;
          presc_d  = '0;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (tick_s) begin
          presc_d = '0;
          cnt_d   = cnt_q - N'(1);
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d  = IDLE;
          cnt_d    = LOAD_V;
          player_d = 1'b0;
          presc_d  = '0;
        end else if (!pause) begin
          state_d = RUN;
        end else begin
          state_d = PAUSE;
        end
      end
      EXPIRE: begin
        if (stop) begin
          state_d  = IDLE;
          cnt_d    = LOAD_V;
          player_d = 1'b0;
          presc_d  = '0;
        end else begin
          state_d  = RUN;
          cnt_d    = LOAD_V;
          player_d = ~player_q;
          presc_d  = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = LOAD_V;
        player_d = 1'b0;
        presc_d  = '0;
      end
    endcase
  end

  assign countdownOut = cnt_q;
  assign player       = player_q;
  assign state        = state_q;
  assign timeout      = (state_q == EXPIRE);
  assign running      = (state_q == RUN);

endmodule

// File: tb/tb_turn_timer_ctrl.sv
// Scoreboard bench for turn_timer_ctrl: a DIV=1 instance and a DIV=3 instance
// share stimulus; a monitor pops expected outputs after each edge or reset event.
module tb_turn_timer_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst3_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, pause = 1'b0, move = 1'b0;

  logic [3:0] cnt1, cnt3;
  logic       pl1, to1, run1, pl3, to3, run3;
  logic [1:0] st1, st3;

  int   n_vec = 0;
  int   n_err = 0;
  logic cur_sel = 1'b0;

  logic [8:0] exp_q[$];
  string      name_q[$];
  logic       sel_q[$];
  event       chk_ev;

  always #5 clk = ~clk;

  turn_timer_ctrl #(.N(4), .LOAD(15), .DIV(1)) dut (
    .clk(clk), .reset(rst_n), .start(start), .stop(stop), .pause(pause), .move(move),
    .countdownOut(cnt1), .player(pl1), .timeout(to1), .running(run1), .state(st1)
  );

  turn_timer_ctrl #(.N(4), .LOAD(15), .DIV(3)) dut3 (
    .clk(clk), .reset(rst3_n), .start(start), .stop(stop), .pause(pause), .move(move),
    .countdownOut(cnt3), .player(pl3), .timeout(to3), .running(run3), .state(st3)
  );

  function automatic logic [8:0] pack_exp(input logic [1:0] es, input int ec, input logic ep);
    logic [3:0] c4;
    c4 = ec[3:0];
    return {es, c4, ep, (es == 2'b11), (es == 2'b01)};
  endfunction

  // Monitor: compare DUT outputs 1 time unit after each edge or async check.
  always begin
    logic [8:0] e, a;
    string nm;
    logic sl;
    @(posedge clk or chk_ev);
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      sl = sel_q.pop_front();
      a  = sl ? {st3, cnt3, pl3, to3, run3} : {st1, cnt1, pl1, to1, run1};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got st=%b cnt=%0d pl=%b to=%b run=%b, want st=%b cnt=%0d pl=%b to=%b run=%b",
                 nm, a[8:7], a[6:3], a[2], a[1], a[0], e[8:7], e[6:3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic step(input logic s_i, input logic p_i, input logic pa_i, input logic m_i,
                      input logic [1:0] es, input int ec, input logic ep, input string nm);
    @(negedge clk);
    start = s_i; stop = p_i; pause = pa_i; move = m_i;
    exp_q.push_back(pack_exp(es, ec, ep));
    name_q.push_back(nm);
    sel_q.push_back(cur_sel);
  endtask

  task automatic async_check(input string nm);
    exp_q.push_back(pack_exp(2'b00, 15, 1'b0));
    name_q.push_back(nm);
    sel_q.push_back(cur_sel);
    -> chk_ev;
    #2;
  endtask

  initial begin
    // Reset state, checked with no clock edge involved.
    @(negedge clk); #2;
    async_check("reset_state");
    @(negedge clk); rst_n = 1'b1;

    // Full turn with no move; start during RUN ignored.
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 15, 1'b0, "start");
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 14, 1'b0, "start_ignored");
    for (int i = 13; i >= 0; i--) step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, i, 1'b0, "countdown");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 0, 1'b0, "expire");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 15, 1'b1, "after_expire");

    // Move at 9.
    for (int i = 14; i >= 9; i--) step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, i, 1'b1, "count_p1");
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 15, 1'b0, "move_at_9");

    // Pause 5 cycles at 7, move during pause ignored, then resume.
    for (int i = 14; i >= 7; i--) step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, i, 1'b0, "count_to_7");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, (i == 2), 2'b10, 7, 1'b0, "paused");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 7, 1'b0, "resume");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 6, 1'b0, "resume_6");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5, 1'b0, "resume_5");

    // Move coinciding with zero count: expire wins, single toggle.
    for (int i = 4; i >= 0; i--) step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, i, 1'b0, "count_to_0");
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 0, 1'b0, "move_at_0_expire");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 15, 1'b1, "move_at_0_toggle");

    // Stop in RUN; IDLE ignores move/pause and start+stop.
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 14, 1'b1, "pre_stop");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 15, 1'b0, "stop_run");
    step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 15, 1'b0, "idle_ignores");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 15, 1'b0, "start_with_stop");
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 15, 1'b0, "restart");

    // Stop while leaving EXPIRE.
    for (int i = 14; i >= 0; i--) step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, i, 1'b0, "count_b");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 0, 1'b0, "expire_b");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 15, 1'b0, "stop_expire");

    // Stop in PAUSE.
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 15, 1'b0, "start_c");
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 15, 1'b0, "pause_c");
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 15, 1'b0, "stop_pause");

    // Async reset mid-RUN at 4.
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 15, 1'b0, "start_d");
    for (int i = 14; i >= 4; i--) step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, i, 1'b0, "count_d");
    @(negedge clk); #2;
    rst_n = 1'b0;
    async_check("async_reset");
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 15, 1'b0, "wait_idle");
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 15, 1'b0, "restart_d");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 14, 1'b0, "restart_14");

    // DIV=3 instance: decrement every 3 cycles, move clears prescaler, stop.
    @(negedge clk);
    cur_sel = 1'b1;
    rst_n   = 1'b0;
    rst3_n  = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 15, 1'b0, "div3_start");
    for (int e = 1; e <= 7; e++) step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 15 - e / 3, 1'b0, "div3_count");
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 15, 1'b1, "div3_move");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 15, 1'b1, "div3_presc1");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 15, 1'b1, "div3_presc2");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 14, 1'b1, "div3_tick");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 15, 1'b0, "div3_stop");

    @(negedge clk);
    start = 1'b0; stop = 1'b0; pause = 1'b0; move = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
